axi_dma_write_master_v2: RTL

Parametrised AXI4-Full write-master engine for the DMA write path. It drains a FWFT FIFO and writes to memory through AW/W/B bursts. Over the current write master it adds:
- configurable data width and maximum burst length
- byte-granular length with a masked final-beat WSTRB
- 4 KB boundary splitting
- BRESP error capture with abort
It sits between the DMA control registers/FIFO and the AXI interconnect; its AR/R tie-offs remain in the wrapper.

---
 rtl/axi_dma_write_master_v2_if.sv | 34 +++
 rtl/axi_dma_write_master_v2.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/axi_dma_write_master_v2_if.sv
// rtl/axi_dma_write_master_v2_if.sv - AXI4 write-channel bundle (AW/W/B) for the DMA write master
interface axi_dma_write_master_v2_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   m_axi_awaddr;
    logic [7:0]              m_axi_awlen;
    logic [2:0]              m_axi_awsize;
    logic [1:0]              m_axi_awburst;
    logic                    m_axi_awvalid;
    logic                    m_axi_awready;
    logic [DATA_WIDTH-1:0]   m_axi_wdata;
    logic [DATA_WIDTH/8-1:0] m_axi_wstrb;
    logic                    m_axi_wlast;
    logic                    m_axi_wvalid;
    logic                    m_axi_wready;
    logic [1:0]              m_axi_bresp;
    logic                    m_axi_bvalid;
    logic                    m_axi_bready;

    modport master (
        output m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
        output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        output m_axi_bready,
        input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid
    );

    modport slave (
        input  m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        input  m_axi_bready,
        output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid
    );
endinterface

// File: rtl/axi_dma_write_master_v2.sv
// rtl/axi_dma_write_master_v2.sv - AXI4 burst write master draining a FWFT FIFO, 4 KB split, BRESP abort
module axi_dma_write_master_v2 #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_MAX_BURST_LEN    = 16,
    parameter int C_LEN_WIDTH        = 32
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESETN,
    input  logic                          i_start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_dst_addr,
    input  logic [C_LEN_WIDTH-1:0]        i_total_len,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] i_w_data,
    input  logic                          i_fifo_empty,
    output logic                          o_fifo_rd_en,
    output logic                          o_busy,
    output logic                          o_write_done,
    output logic                          o_error,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] o_err_addr,
    axi_dma_write_master_v2_if.master     m_axi
);
    localparam int BYTES = C_M_AXI_DATA_WIDTH / 8;
    localparam int SIZE  = $clog2(BYTES);
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] LOW_MASK = C_M_AXI_ADDR_WIDTH'(BYTES - 1);

    typedef enum logic [2:0] {S_IDLE, S_ZERO, S_AW, S_W, S_B, S_DONE} state_t;

    state_t                        state, next_state;
    logic [C_M_AXI_ADDR_WIDTH-1:0] addr;
    logic [C_LEN_WIDTH-1:0]        beats_left;
    logic [SIZE-1:0]               tail;
    logic [8:0]                    cur_beats;
    logic [8:0]                    beat_cnt;
    logic                          err_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0] err_addr_q;

    logic [C_M_AXI_ADDR_WIDTH-1:0] aligned, next_addr;
    logic [C_LEN_WIDTH-1:0]        total_beats, left_next;
    logic                          w_last, final_beat, wvalid;
    logic [BYTES-1:0]              ones;
    logic                          unused_bits;

    // Beats in the next burst: limited by what is left, the burst cap and the 4 KB page end.
    function automatic logic [8:0] calc_beats(input logic [11:0] a, input logic [C_LEN_WIDTH-1:0] left);
        logic [12:0] space;
        logic [8:0]  b;
        space = (13'd4096 - {1'b0, a}) >> SIZE;
        b = 9'(C_MAX_BURST_LEN);
        if ({4'b0, b} > space) b = space[8:0];
        if (left < {{(C_LEN_WIDTH-9){1'b0}}, b}) b = left[8:0];
        return b;
    endfunction

    assign aligned     = i_dst_addr & ~LOW_MASK;
    assign total_beats = (i_total_len >> SIZE) + {{(C_LEN_WIDTH-1){1'b0}}, |i_total_len[SIZE-1:0]};
    assign next_addr   = addr + ({{(C_M_AXI_ADDR_WIDTH-9){1'b0}}, cur_beats} << SIZE);
    assign left_next   = beats_left - {{(C_LEN_WIDTH-9){1'b0}}, cur_beats};
    assign w_last      = (beat_cnt == cur_beats - 9'd1);
    assign final_beat  = w_last && (beats_left == {{(C_LEN_WIDTH-9){1'b0}}, cur_beats});
    assign ones        = '1;
    assign unused_bits = m_axi.m_axi_bresp[0];

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) state <= S_IDLE;
        else                state <= next_state;
    end

    always_comb begin
        next_state   = state;
        o_busy       = 1'b0;
        o_write_done = 1'b0;
        o_fifo_rd_en = 1'b0;
        wvalid       = 1'b0;
        m_axi.m_axi_awvalid = 1'b0;
        m_axi.m_axi_bready  = 1'b0;
        case (state)
            S_IDLE: if (i_start) next_state = (i_total_len == '0) ? S_ZERO : S_AW;
            S_ZERO: begin
                o_busy     = 1'b1;
                next_state = S_DONE;
            end
            S_AW: begin
                o_busy = 1'b1;
                m_axi.m_axi_awvalid = 1'b1;
                if (m_axi.m_axi_awready) next_state = S_W;
            end
            S_W: begin
                o_busy       = 1'b1;
                wvalid       = !i_fifo_empty;
                o_fifo_rd_en = wvalid && m_axi.m_axi_wready;
                if (o_fifo_rd_en && w_last) next_state = S_B;
            end
            S_B: begin
                o_busy = 1'b1;
                m_axi.m_axi_bready = 1'b1;
                if (m_axi.m_axi_bvalid) begin
                    if (m_axi.m_axi_bresp[1] || left_next == '0) next_state = S_DONE;
                    else                                         next_state = S_AW;
                end
            end
            S_DONE: begin
                o_write_done = 1'b1;
                next_state   = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            addr       <= '0;
            beats_left <= '0;
            tail       <= '0;
            cur_beats  <= '0;
            beat_cnt   <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            case (state)
                S_IDLE: if (i_start) begin
                    addr       <= aligned;
                    beats_left <= total_beats;
                    tail       <= i_total_len[SIZE-1:0];
                    cur_beats  <= calc_beats(aligned[11:0], total_beats);
                    beat_cnt   <= '0;
                    err_q      <= 1'b0;
                end
                S_W: if (o_fifo_rd_en) beat_cnt <= w_last ? 9'd0 : beat_cnt + 9'd1;
                S_B: if (m_axi.m_axi_bvalid) begin
                    if (m_axi.m_axi_bresp[1]) begin
                        err_q <= 1'b1;
                        if (!err_q) err_addr_q <= addr;
                    end else begin
                        addr       <= next_addr;
                        beats_left <= left_next;
                        cur_beats  <= calc_beats(next_addr[11:0], left_next);
                    end
                end
                default: ;
            endcase
        end
    end

    // Channel payloads are held at zero outside their own phase.
    always_comb begin
        m_axi.m_axi_awaddr  = '0;
        m_axi.m_axi_awlen   = '0;
        m_axi.m_axi_awsize  = '0;
        m_axi.m_axi_awburst = '0;
        m_axi.m_axi_wdata   = '0;
        m_axi.m_axi_wstrb   = '0;
        m_axi.m_axi_wlast   = 1'b0;
        if (state == S_AW) begin
            m_axi.m_axi_awaddr  = addr;
            m_axi.m_axi_awlen   = 8'(cur_beats - 9'd1);
            m_axi.m_axi_awsize  = 3'(SIZE);
            m_axi.m_axi_awburst = 2'b01;
        end
        if (state == S_W) begin
            m_axi.m_axi_wdata = i_w_data;
            m_axi.m_axi_wlast = w_last;
            m_axi.m_axi_wstrb = (final_beat && tail != '0) ? ~(ones << tail) : ones;
        end
    end

    assign m_axi.m_axi_wvalid = wvalid;
    assign o_error    = err_q;
    assign o_err_addr = err_addr_q;
endmodule
